// File: rtl/ir_pkg.sv
// Shared constants and helpers for the instruction queue.
package ir_pkg;

   localparam int IR_DATA_W = 16;
   localparam logic [IR_DATA_W-1:0] BUS_IDLE = '0;

   function automatic int ptr_w(input int depth);
      return $clog2(depth);
   endfunction

endpackage

// File: rtl/ir_queue_mem.sv
// Circular storage for the instruction queue: array, pointers, occupancy, full/empty.
module ir_queue_mem
   import ir_pkg::*;
#(
   parameter int DATA_W = IR_DATA_W,
   parameter int DEPTH  = 4,
   parameter int CNT_W  = $clog2(DEPTH) + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic              pop,
   input  logic              flush,
   input  logic [DATA_W-1:0] wr_data,
   output logic [DATA_W-1:0] rd_data,
   output logic [CNT_W-1:0]  count,
   output logic              full,
   output logic              empty
);

   localparam int PW = ptr_w(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;

   // DEPTH is a power of two, so pointer wrap is just natural overflow.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + PW'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
         case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push && !flush) mem[wr_ptr_q] <= wr_data;
   end

   assign rd_data = mem[rd_ptr_q];
   assign count   = count_q;
   assign full    = (count_q == CNT_W'(DEPTH));
   assign empty   = (count_q == '0);

endmodule

// File: rtl/ir_queue.sv
// Instruction queue in front of the CU with registered bus/ALU copies of the head.
// Optional same-cycle empty-queue bypass: define IR_QUEUE_BYPASS_EN.
module ir_queue
   import ir_pkg::*;
#(
   parameter int DATA_W = IR_DATA_W,
   parameter int DEPTH  = 4,
   parameter int CNT_W  = $clog2(DEPTH) + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] im_data,
   input  logic              im_valid,
   output logic              im_ready,
   input  logic              flush,
   output logic [DATA_W-1:0] cu_instr,
   output logic              cu_valid,
   input  logic              cu_take,
   input  logic              ld_bus,
   input  logic              ld_alu,
   output logic [DATA_W-1:0] bus_out,
   output logic              bus_oe,
   output logic [DATA_W-1:0] alu_out,
   output logic [CNT_W-1:0]  count
);

   logic [DATA_W-1:0] rd_data;
   logic              full, empty;
   logic              push, pop;
   logic [DATA_W-1:0] bus_out_q, bus_out_d;
   logic              bus_oe_q, bus_oe_d;
   logic [DATA_W-1:0] alu_out_q, alu_out_d;

   ir_queue_mem #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .CNT_W  (CNT_W)
   ) u_mem (
      .clk     (clk),
      .rst     (rst),
      .push    (push),
      .pop     (pop),
      .flush   (flush),
      .wr_data (im_data),
      .rd_data (rd_data),
      .count   (count),
      .full    (full),
      .empty   (empty)
   );

   always_comb begin
      im_ready = !full && !flush;
      cu_valid = !empty && !flush;
      cu_instr = rd_data;
      push     = im_valid && im_ready;
      pop      = cu_take && cu_valid;
`ifdef IR_QUEUE_BYPASS_EN
      // A word arriving at an empty queue is offered directly; if taken it is never stored.
      if (empty && im_valid && !flush) begin
         cu_valid = 1'b1;
         cu_instr = im_data;
         push     = !cu_take;
         pop      = 1'b0;
      end
`endif
   end

   // Loads copy the pre-pop head; flush idles the bus but leaves the ALU operand alone.
   always_comb begin
      bus_out_d = DATA_W'(BUS_IDLE);
      bus_oe_d  = 1'b0;
      alu_out_d = alu_out_q;
      if (!flush) begin
         if (ld_bus && cu_valid) begin
            bus_out_d = cu_instr;
            bus_oe_d  = 1'b1;
         end else if (ld_alu && cu_valid) begin
            alu_out_d = cu_instr;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus_out_q <= DATA_W'(BUS_IDLE);
         bus_oe_q  <= 1'b0;
         alu_out_q <= '0;
      end else begin
         bus_out_q <= bus_out_d;
         bus_oe_q  <= bus_oe_d;
         alu_out_q <= alu_out_d;
      end
   end

   assign bus_out = bus_out_q;
   assign bus_oe  = bus_oe_q;
   assign alu_out = alu_out_q;

endmodule

// File: tb/tb_ir_queue.sv
// Directed self-checking bench for ir_queue (default build or IR_QUEUE_BYPASS_EN).
module tb_ir_queue;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] im_data;
   logic        im_valid;
   logic        im_ready;
   logic        flush;
   logic [15:0] cu_instr;
   logic        cu_valid;
   logic        cu_take;
   logic        ld_bus;
   logic        ld_alu;
   logic [15:0] bus_out;
   logic        bus_oe;
   logic [15:0] alu_out;
   logic [2:0]  count;

   int n_checks = 0;
   int n_fails  = 0;

   ir_queue #(.DATA_W(16), .DEPTH(4)) dut (
      .clk      (clk),
      .rst      (rst),
      .im_data  (im_data),
      .im_valid (im_valid),
      .im_ready (im_ready),
      .flush    (flush),
      .cu_instr (cu_instr),
      .cu_valid (cu_valid),
      .cu_take  (cu_take),
      .ld_bus   (ld_bus),
      .ld_alu   (ld_alu),
      .bus_out  (bus_out),
      .bus_oe   (bus_oe),
      .alu_out  (alu_out),
      .count    (count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance past the next rising edge; inputs and checks happen 1ns later.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_word(input logic [15:0] w);
      im_valid = 1'b1;
      im_data  = w;
      tick();
      im_valid = 1'b0;
   endtask

   initial begin
      rst = 1'b1; im_data = '0; im_valid = 1'b0; flush = 1'b0;
      cu_take = 1'b0; ld_bus = 1'b0; ld_alu = 1'b0;
      tick(); tick();
      rst = 1'b0;
      #1;
      chk("rst_count", count, 0);
      chk("rst_cu_valid", cu_valid, 0);
      chk("rst_im_ready", im_ready, 1);
      chk("rst_bus_oe", bus_oe, 0);
      chk("rst_bus_out", bus_out, 0);
      chk("rst_alu_out", alu_out, 0);
      $display("reset released: count=%0d im_ready=%0b", count, im_ready);

      // Fill to capacity, then try a fifth word.
      push_word(16'h1111);
      chk("fill1_cu_instr", cu_instr, 16'h1111);
      chk("fill1_count", count, 1);
      push_word(16'h2222);
      push_word(16'h3333);
      push_word(16'h4444);
      im_valid = 1'b1; im_data = 16'h5555;
      #1;
      chk("full_count", count, 4);
      chk("full_im_ready", im_ready, 0);
      chk("full_cu_instr", cu_instr, 16'h1111);
      tick();
      im_valid = 1'b0;
      chk("refused_count", count, 4);
      chk("refused_cu_instr", cu_instr, 16'h1111);
      $display("fill: count=%0d head=%h", count, cu_instr);

      // Drain while pushing AAAA on the second take cycle; no pass-through while full.
      cu_take = 1'b1;
      #1;
      chk("pop1_head", cu_instr, 16'h1111);
      chk("pop1_im_ready", im_ready, 0);
      tick();
      chk("pop1_count", count, 3);
      im_valid = 1'b1; im_data = 16'hAAAA;
      #1;
      chk("pop2_head", cu_instr, 16'h2222);
      chk("pop2_im_ready", im_ready, 1);
      tick();
      im_valid = 1'b0;
      chk("pop2_count", count, 3);
      chk("pop3_head", cu_instr, 16'h3333);
      tick();
      chk("pop3_count", count, 2);
      chk("pop4_head", cu_instr, 16'h4444);
      tick();
      cu_take = 1'b0;
      #1;
      chk("wrap_head", cu_instr, 16'hAAAA);
      chk("wrap_count", count, 1);
      chk("wrap_cu_valid", cu_valid, 1);
      cu_take = 1'b1;
      tick();
      cu_take = 1'b0;
      chk("drained_count", count, 0);
      chk("drained_cu_valid", cu_valid, 0);
      $display("drain: count=%0d", count);

      // Bus has priority over ALU; bus drive lasts one cycle.
      push_word(16'hBEEF);
      chk("beef_head", cu_instr, 16'hBEEF);
      ld_bus = 1'b1; ld_alu = 1'b1;
      tick();
      ld_bus = 1'b0; ld_alu = 1'b0;
      chk("ldbus_bus_out", bus_out, 16'hBEEF);
      chk("ldbus_bus_oe", bus_oe, 1);
      chk("ldbus_alu_hold", alu_out, 16'h0000);
      tick();
      chk("bus_release_out", bus_out, 0);
      chk("bus_release_oe", bus_oe, 0);
      ld_alu = 1'b1;
      tick();
      ld_alu = 1'b0;
      chk("ldalu_alu_out", alu_out, 16'hBEEF);
      chk("ldalu_bus_oe", bus_oe, 0);
      chk("ldalu_count", count, 1);
      $display("loads: bus_out=%h alu_out=%h", bus_out, alu_out);

      // Flush overrides push, pop and both loads; alu_out holds.
      cu_take = 1'b1;
      tick();
      cu_take = 1'b0;
      push_word(16'h0101);
      push_word(16'h0202);
      push_word(16'h0303);
      chk("preflush_count", count, 3);
      chk("preflush_head", cu_instr, 16'h0101);
      flush = 1'b1; im_valid = 1'b1; im_data = 16'h0404;
      cu_take = 1'b1; ld_bus = 1'b1; ld_alu = 1'b1;
      #1;
      chk("flush_im_ready", im_ready, 0);
      chk("flush_cu_valid", cu_valid, 0);
      tick();
      flush = 1'b0; im_valid = 1'b0; cu_take = 1'b0; ld_bus = 1'b0; ld_alu = 1'b0;
      #1;
      chk("postflush_count", count, 0);
      chk("postflush_cu_valid", cu_valid, 0);
      chk("postflush_alu_out", alu_out, 16'hBEEF);
      chk("postflush_bus_oe", bus_oe, 0);
      $display("flush: count=%0d alu_out=%h", count, alu_out);

      // Async reset mid-stream with the bus driven.
      push_word(16'h0A0A);
      push_word(16'h0B0B);
      ld_bus = 1'b1;
      tick();
      ld_bus = 1'b0;
      chk("prerst_count", count, 2);
      chk("prerst_bus_oe", bus_oe, 1);
      chk("prerst_bus_out", bus_out, 16'h0A0A);
      rst = 1'b1;
      #1;
      chk("async_rst_count", count, 0);
      chk("async_rst_bus_oe", bus_oe, 0);
      chk("async_rst_bus_out", bus_out, 0);
      chk("async_rst_alu_out", alu_out, 0);
      chk("async_rst_cu_valid", cu_valid, 0);
      tick();
      rst = 1'b0;
      #1;
      $display("async reset: count=%0d bus_oe=%0b", count, bus_oe);

      // Empty-queue word with take asserted.
      im_valid = 1'b1; im_data = 16'h1234; cu_take = 1'b1;
      #1;
`ifdef IR_QUEUE_BYPASS_EN
      chk("byp_cu_valid", cu_valid, 1);
      chk("byp_cu_instr", cu_instr, 16'h1234);
      tick();
      im_valid = 1'b0; cu_take = 1'b0;
      #1;
      chk("byp_count", count, 0);
      chk("byp_cu_valid_after", cu_valid, 0);
`else
      chk("nobyp_cu_valid", cu_valid, 0);
      tick();
      im_valid = 1'b0; cu_take = 1'b0;
      #1;
      chk("nobyp_count", count, 1);
      chk("nobyp_cu_valid_after", cu_valid, 1);
      chk("nobyp_cu_instr", cu_instr, 16'h1234);
`endif
      $display("empty-queue word: count=%0d cu_valid=%0b", count, cu_valid);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
